// File: rtl/countdown_pkg.sv
// countdown_pkg
//   Shared types and helpers for the countdown timer.
//   - state_t : timer FSM states
//   - eff_div : effective prescaler divisor, a divisor of 0 behaves as 1
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Divisor arithmetic is carried out at this fixed width so one helper
    // serves every DIV_WIDTH up to 64.
    localparam int DIV_MAX_W = 64;

    function automatic logic [DIV_MAX_W-1:0] eff_div(input logic [DIV_MAX_W-1:0] div);
        return (div == '0) ? DIV_MAX_W'(1) : div;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if
//   Control/status bundle of the countdown timer.
//   master : drives load/load_value/start/pause/tick_div, observes status
//   slave  : the timer; drives remaining/running/expired/expire_pulse
interface countdown_timer_if #(
    parameter int WIDTH     = 32,
    parameter int DIV_WIDTH = 32
);
    logic                 load;
    logic [WIDTH-1:0]     load_value;
    logic                 start;
    logic                 pause;
    logic [DIV_WIDTH-1:0] tick_div;
    logic [WIDTH-1:0]     remaining;
    logic                 running;
    logic                 expired;
    logic                 expire_pulse;

    modport master (
        output load, load_value, start, pause, tick_div,
        input  remaining, running, expired, expire_pulse
    );

    modport slave (
        input  load, load_value, start, pause, tick_div,
        output remaining, running, expired, expire_pulse
    );
endinterface

// File: rtl/tick_gen.sv
// tick_gen
//   Prescaler for the countdown timer. Counts CLK cycles while advance_i is
//   high and emits a one-cycle tick when the count has reached eff_div-1.
//   Ports:
//     CLK, RESET  : clock, synchronous active-high reset
//     clear_i     : force the count back to 0 (load)
//     advance_i   : count this cycle; count is held when low
//     tick_div_i  : CLK cycles per tick (0 behaves as 1)
//     tick_o      : tick strobe, only while advancing
module tick_gen
    import countdown_pkg::*;
#(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 clear_i,
    input  logic                 advance_i,
    input  logic [DIV_WIDTH-1:0] tick_div_i,
    output logic                 tick_o
);
    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic                 due;

    // >= rather than == so a divisor lowered mid-run below the current
    // phase fires on the next advancing cycle instead of wrapping around.
    assign due    = DIV_MAX_W'(count_q) >= (eff_div(DIV_MAX_W'(tick_div_i)) - DIV_MAX_W'(1));
    assign tick_o = advance_i & ~clear_i & due;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (advance_i)
            count_d = due ? '0 : count_q + DIV_WIDTH'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer
//   Loadable down-counting seconds timer. A prescaler (tick_gen) divides CLK
//   into ticks; each tick in RUN decrements the remaining count. Reaching 0
//   enters DONE, signalled as a level (expired) and a one-cycle strobe
//   (expire_pulse).
//   Ports:
//     CLK, RESET : clock, synchronous active-high reset
//     bus        : countdown_timer_if.slave
//                  in : load, load_value, start, pause, tick_div
//                  out: remaining, running, expired, expire_pulse (registered)
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    countdown_timer_if.slave   bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             pulse_q, pulse_d;

    logic             advance;
    logic             tick;

    // Pause wins over a due tick, and load overrides everything, so neither
    // may advance the prescaler.
    assign advance = (state_q == RUN) & ~bus.pause & ~bus.load;

    tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear_i    (bus.load),
        .advance_i  (advance),
        .tick_div_i (bus.tick_div),
        .tick_o     (tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pulse_d     = 1'b0;

        if (bus.load) begin
            state_d     = IDLE;
            remaining_d = bus.load_value;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (remaining_q == '0) begin
                            state_d = DONE;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        remaining_d = remaining_q - WIDTH'(1);
                        // DONE lands on the same edge remaining hits 0, so
                        // remaining can never be decremented from 0.
                        if (remaining_q == WIDTH'(1)) begin
                            state_d = DONE;
                            pulse_d = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start && !bus.pause)
                        state_d = RUN;
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end

        // Status levels are registered alongside the state they describe.
        running_d = (state_d == RUN);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            pulse_q     <= pulse_d;
        end
    end

    assign bus.remaining    = remaining_q;
    assign bus.running      = running_q;
    assign bus.expired      = expired_q;
    assign bus.expire_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
    localparam int W  = 32;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    countdown_timer_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus ();

    countdown_timer #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        load;
        int unsigned lv;
        logic        start;
        logic        pause;
        int unsigned div;
        int unsigned e_rem;
        logic        e_run;
        logic        e_exp;
        logic        e_pulse;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic l, int unsigned lv, logic s, logic p, int unsigned d,
                                int unsigned rem, logic run, logic ex, logic pl);
        vec_t v;
        v.load = l; v.lv = lv; v.start = s; v.pause = p; v.div = d;
        v.e_rem = rem; v.e_run = run; v.e_exp = ex; v.e_pulse = pl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic l, input int unsigned lv, input logic s, input logic p,
                         input int unsigned d);
        bus.load       = l;
        bus.load_value = W'(lv);
        bus.start      = s;
        bus.pause      = p;
        bus.tick_div   = DW'(d);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input int unsigned rem, input logic run,
                           input logic ex, input logic pl);
        chk({tag, ".remaining"}, bus.remaining, rem);
        chk({tag, ".running"}, bus.running, run);
        chk({tag, ".expired"}, bus.expired, ex);
        chk({tag, ".expire_pulse"}, bus.expire_pulse, pl);
    endtask

    // Behavioural reference: mode 0 idle, 1 counting, 2 paused, 3 finished.
    int m_rem, m_ph, m_mode;
    bit m_pulse;

    task automatic model_step(input logic rst, input logic l, input int unsigned lv,
                              input logic s, input logic p, input int unsigned d);
        int div;
        m_pulse = 0;
        div = (d == 0) ? 1 : int'(d);
        if (rst) begin
            m_rem = 0; m_ph = 0; m_mode = 0;
        end else if (l) begin
            m_rem = int'(lv); m_ph = 0; m_mode = 0;
        end else if (m_mode == 0) begin
            if (s) begin
                if (m_rem == 0) begin m_mode = 3; m_pulse = 1; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (p) m_mode = 2;
            else if (m_ph + 1 >= div) begin
                m_ph = 0;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_mode = 3; m_pulse = 1; end
            end else m_ph = m_ph + 1;
        end else if (m_mode == 2) begin
            if (s && !p) m_mode = 1;
        end
    endtask

    initial begin
        int pulses;
        int bad;
        int unsigned d;
        logic l, s, p, r;
        int unsigned lv;

        // ---------------- reset state ----------------
        RESET = 1'b1;
        drive(0, 0, 0, 0, 4);
        step(); step();
        chk_all("reset", 0, 0, 0, 0);
        RESET = 1'b0;

        // ---------------- table-driven vectors ----------------
        // tick_div=0: decrement every cycle, DONE 2 cycles after start
        vecs.push_back(mk(1, 2, 0, 0, 0,  2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,  2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 0));
        // load 0, start -> DONE at once; start/pause ignored; load 7 leaves DONE
        vecs.push_back(mk(1, 0, 0, 0, 4,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4,  0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 4,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4,  0, 0, 1, 0));
        vecs.push_back(mk(1, 7, 0, 0, 4,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4,  7, 0, 0, 0));
        // pause beats a due tick (div=1); start+pause stays paused
        vecs.push_back(mk(1, 4, 0, 0, 1,  4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,  4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1,  4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1,  4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1,  4, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  3, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].pause, vecs[i].div);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rem, vecs[i].e_run,
                    vecs[i].e_exp, vecs[i].e_pulse);
        end

        // ---------------- load 3, div 4: 3,2,1,0 at 4-cycle spacing ----------------
        drive(1, 3, 0, 0, 4); step();
        drive(0, 0, 1, 0, 4); step();
        chk_all("seq1.start", 3, 1, 0, 0);
        drive(0, 0, 0, 0, 4);
        pulses = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (bus.expire_pulse) pulses++;
            if (i == 3)  chk("seq1.rem@3", bus.remaining, 3);
            if (i == 4)  chk("seq1.rem@4", bus.remaining, 2);
            if (i == 7)  chk("seq1.rem@7", bus.remaining, 2);
            if (i == 8)  chk("seq1.rem@8", bus.remaining, 1);
            if (i == 11) chk_all("seq1.c11", 1, 1, 0, 0);
            if (i == 12) chk_all("seq1.c12", 0, 0, 1, 1);
        end
        chk("seq1.pulse_count", pulses, 1);

        // ---------------- pause mid-period, resume finishes the period ----------------
        drive(1, 5, 0, 0, 4); step();
        drive(0, 0, 1, 0, 4); step();
        drive(0, 0, 0, 0, 4);
        for (int i = 1; i <= 6; i++) step();
        chk("seq2.rem_before_pause", bus.remaining, 4);
        drive(0, 0, 0, 1, 4);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.remaining !== 4 || bus.running !== 1'b0) bad++;
        end
        chk("seq2.paused_hold_errors", bad, 0);
        drive(0, 0, 1, 0, 4); step();
        chk_all("seq2.resume", 4, 1, 0, 0);
        drive(0, 0, 0, 0, 4); step();
        chk("seq2.resume+1", bus.remaining, 4);
        step();
        chk("seq2.resume+2", bus.remaining, 3);

        // ---------------- mid-run load clears the prescaler ----------------
        drive(1, 3, 0, 0, 4); step();
        drive(0, 0, 1, 0, 4); step();
        drive(0, 0, 0, 0, 4);
        for (int i = 1; i <= 5; i++) step();
        chk("seq3.rem_before_load", bus.remaining, 2);
        drive(1, 9, 0, 0, 4); step();
        chk_all("seq3.load", 9, 0, 0, 0);
        drive(0, 0, 1, 0, 4); step();
        drive(0, 0, 0, 0, 4);
        step(); step(); step();
        chk("seq3.rem@3", bus.remaining, 9);
        step();
        chk("seq3.rem@4", bus.remaining, 8);

        // ---------------- reset on the edge the final tick was due ----------------
        drive(1, 1, 0, 0, 4); step();
        drive(0, 0, 1, 0, 4); step();
        drive(0, 0, 0, 0, 4);
        step(); step(); step();
        chk_all("seq4.pre_reset", 1, 1, 0, 0);
        RESET = 1'b1; step();
        chk_all("seq4.reset", 0, 0, 0, 0);
        RESET = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.expire_pulse || bus.expired) pulses++;
        end
        chk("seq4.no_expiry", pulses, 0);

        // ---------------- randomized run against the reference model ----------------
        RESET = 1'b1; drive(0, 0, 0, 0, 2);
        model_step(1, 0, 0, 0, 0, 2);
        step();
        RESET = 1'b0;
        d = 2;
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            l  = ($urandom_range(0, 29) == 0);
            lv = $urandom_range(0, 6);
            s  = ($urandom_range(0, 5) == 0);
            p  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) d = $urandom_range(0, 5);
            RESET = r;
            drive(l, lv, s, p, d);
            model_step(r, l, lv, s, p, d);
            step();
            chk_all($sformatf("rnd%0d", c), m_rem, m_mode == 1, m_mode == 3, m_pulse);
        end
        RESET = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
